// File: rtl/device1_tx_if.sv
// Lane-side bundle of the two-lane serial transmitter: byte writes in, serial bits and flow-control flags out.
interface device1_tx_if #(
  parameter int unsigned DATA_SIZE = 8
);
  logic                 push0;
  logic                 push1;
  logic [DATA_SIZE-1:0] data_in0;
  logic [DATA_SIZE-1:0] data_in1;
  logic                 out0;
  logic                 out1;
  logic                 almost_full_f0;
  logic                 almost_full_f1;
  logic                 full_f0;
  logic                 full_f1;
  logic                 err0;
  logic                 err1;
  logic                 active;

  modport master (
    output push0, push1, data_in0, data_in1,
    input  out0, out1, almost_full_f0, almost_full_f1, full_f0, full_f1, err0, err1, active
  );

  modport slave (
    input  push0, push1, data_in0, data_in1,
    output out0, out1, almost_full_f0, almost_full_f1, full_f0, full_f1, err0, err1, active
  );
endinterface

// File: rtl/device1_tx.sv
// Two-lane transmitter: per-lane byte FIFO feeding an MSB-first serializer, with comma training after reset.
module device1_tx #(
  parameter int unsigned          DATA_SIZE  = 8,
  parameter int unsigned          FIFO_DEPTH = 4,
  parameter int unsigned          AF_TH      = 3,
  parameter logic [DATA_SIZE-1:0] COMMA      = DATA_SIZE'(8'hBC),
  parameter int unsigned          TRAIN_SYMS = 4
) (
  input  logic           clk8f,
  input  logic           reset,
  device1_tx_if.slave    bus
);

  localparam int unsigned CNT_W = (DATA_SIZE > 1) ? $clog2(DATA_SIZE) : 1;
  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned OCC_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned TRN_W = (TRAIN_SYMS > 1) ? $clog2(TRAIN_SYMS) : 1;
  localparam int unsigned LANES = 2;

  typedef enum logic {
    S_TRAIN = 1'b0,
    S_RUN   = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [TRN_W-1:0]   train_cnt_q, train_cnt_d;
  logic               active_q, active_d;
  logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic               load_c;

  logic [LANES-1:0]     push_w;
  logic [DATA_SIZE-1:0] din_w [LANES];
  logic [LANES-1:0]     ser_w;
  logic [LANES-1:0]     af_w;
  logic [LANES-1:0]     full_w;
  logic [LANES-1:0]     err_w;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign push_w    = {bus.push1, bus.push0};
  assign din_w[0]  = bus.data_in0;
  assign din_w[1]  = bus.data_in1;

  // Shared symbol timing: the edge that sees the last bit slot loads a new symbol
  assign load_c    = (bit_cnt_q == CNT_W'(DATA_SIZE - 1));
  assign bit_cnt_d = load_c ? '0 : bit_cnt_q + CNT_W'(1);

  always_comb begin
    state_d     = state_q;
    train_cnt_d = train_cnt_q;
    active_d    = active_q;
    case (state_q)
      S_TRAIN: begin
        if (load_c) begin
          train_cnt_d = train_cnt_q + TRN_W'(1);
          if (train_cnt_q == TRN_W'(TRAIN_SYMS - 1)) begin
            state_d  = S_RUN;
            active_d = 1'b1;
          end
        end
      end
      S_RUN: begin
        state_d = S_RUN;
      end
      default: begin
        state_d = S_TRAIN;
      end
    endcase
  end

  always_ff @(posedge clk8f) begin
    if (!reset) begin
      state_q     <= S_TRAIN;
      train_cnt_q <= '0;
      active_q    <= 1'b0;
      bit_cnt_q   <= CNT_W'(DATA_SIZE - 1);
    end else begin
      state_q     <= state_d;
      train_cnt_q <= train_cnt_d;
      active_q    <= active_d;
      bit_cnt_q   <= bit_cnt_d;
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [DATA_SIZE-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]     rptr_q, rptr_d;
    logic [PTR_W-1:0]     wptr_q, wptr_d;
    logic [OCC_W-1:0]     occ_q, occ_d;
    logic [DATA_SIZE-1:0] shift_q, shift_d;
    logic                 af_q, af_d;
    logic                 full_q, full_d;
    logic                 err_q, err_d;
    logic                 pop_c, wr_c, ovf_c;

    // Pop uses pre-edge occupancy; a full FIFO still accepts a write when it pops on the same edge
    always_comb begin
      pop_c   = load_c && (state_q == S_RUN) && (occ_q != '0);
      wr_c    = push_w[l] && ((occ_q != OCC_W'(FIFO_DEPTH)) || pop_c);
      ovf_c   = push_w[l] && !wr_c;
      rptr_d  = pop_c ? ptr_inc(rptr_q) : rptr_q;
      wptr_d  = wr_c ? ptr_inc(wptr_q) : wptr_q;
      occ_d   = occ_q + OCC_W'(wr_c) - OCC_W'(pop_c);
      shift_d = {shift_q[DATA_SIZE-2:0], 1'b0};
      if (load_c) begin
        shift_d = pop_c ? mem_q[rptr_q] : COMMA;
      end
      err_d   = err_q | ovf_c;
      af_d    = (occ_d >= OCC_W'(AF_TH));
      full_d  = (occ_d == OCC_W'(FIFO_DEPTH));
    end

    always_ff @(posedge clk8f) begin
      if (!reset) begin
        for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
          mem_q[i] <= '0;
        end
        rptr_q  <= '0;
        wptr_q  <= '0;
        occ_q   <= '0;
        shift_q <= '0;
        af_q    <= 1'b0;
        full_q  <= 1'b0;
        err_q   <= 1'b0;
      end else begin
        if (wr_c) begin
          mem_q[wptr_q] <= din_w[l];
        end
        rptr_q  <= rptr_d;
        wptr_q  <= wptr_d;
        occ_q   <= occ_d;
        shift_q <= shift_d;
        af_q    <= af_d;
        full_q  <= full_d;
        err_q   <= err_d;
      end
    end

    assign ser_w[l]  = shift_q[DATA_SIZE-1];
    assign af_w[l]   = af_q;
    assign full_w[l] = full_q;
    assign err_w[l]  = err_q;
  end

  assign bus.out0           = ser_w[0];
  assign bus.out1           = ser_w[1];
  assign bus.almost_full_f0 = af_w[0];
  assign bus.almost_full_f1 = af_w[1];
  assign bus.full_f0        = full_w[0];
  assign bus.full_f1        = full_w[1];
  assign bus.err0           = err_w[0];
  assign bus.err1           = err_w[1];
  assign bus.active         = active_q;

endmodule

// File: tb/tb_device1_tx.sv
// Bench for device1_tx: directed scenarios plus random pushes, checked every cycle against a queue-based link model.
module tb_device1_tx;

  localparam int         DATA_SIZE  = 8;
  localparam int         FIFO_DEPTH = 4;
  localparam int         AF_TH      = 3;
  localparam logic [7:0] COMMA      = 8'hBC;
  localparam int         TRAIN_SYMS = 4;

  logic clk;
  logic rst_n;

  device1_tx_if #(.DATA_SIZE(DATA_SIZE)) bus ();

  device1_tx #(
    .DATA_SIZE (DATA_SIZE),
    .FIFO_DEPTH(FIFO_DEPTH),
    .AF_TH     (AF_TH),
    .COMMA     (COMMA),
    .TRAIN_SYMS(TRAIN_SYMS)
  ) u_dut (
    .clk8f(clk),
    .reset(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Link model: byte queues per lane, symbols on air, cycles since the last symbol boundary
  logic [7:0] mq0[$];
  logic [7:0] mq1[$];
  logic [7:0] m_sym0, m_sym1;
  int         m_loads;
  int         m_since;
  logic       m_err0, m_err1;

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %b expected %b (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_edge(input bit r, input bit p0, input bit p1,
                            input logic [7:0] d0, input logic [7:0] d1);
    bit trained;
    if (!r) begin
      mq0.delete();
      mq1.delete();
      m_loads = 0;
      m_since = DATA_SIZE - 1;
      m_sym0  = 8'h00;
      m_sym1  = 8'h00;
      m_err0  = 1'b0;
      m_err1  = 1'b0;
    end else begin
      if (m_since == DATA_SIZE - 1) begin
        trained = (m_loads >= TRAIN_SYMS);
        m_sym0  = COMMA;
        m_sym1  = COMMA;
        if (trained && mq0.size() > 0) m_sym0 = mq0.pop_front();
        if (trained && mq1.size() > 0) m_sym1 = mq1.pop_front();
        m_loads++;
        m_since = 0;
      end else begin
        m_since++;
      end
      if (p0) begin
        if (mq0.size() < FIFO_DEPTH) mq0.push_back(d0);
        else m_err0 = 1'b1;
      end
      if (p1) begin
        if (mq1.size() < FIFO_DEPTH) mq1.push_back(d1);
        else m_err1 = 1'b1;
      end
    end
  endtask

  task automatic step(input bit r, input bit p0, input bit p1,
                      input logic [7:0] d0, input logic [7:0] d1);
    @(negedge clk);
    rst_n        = r;
    bus.push0    = p0;
    bus.push1    = p1;
    bus.data_in0 = d0;
    bus.data_in1 = d1;
    @(posedge clk);
    model_edge(r, p0, p1, d0, d1);
    #1;
    chk("out0",   bus.out0,           m_sym0[DATA_SIZE-1-m_since]);
    chk("out1",   bus.out1,           m_sym1[DATA_SIZE-1-m_since]);
    chk("af0",    bus.almost_full_f0, mq0.size() >= AF_TH);
    chk("af1",    bus.almost_full_f1, mq1.size() >= AF_TH);
    chk("full0",  bus.full_f0,        mq0.size() == FIFO_DEPTH);
    chk("full1",  bus.full_f1,        mq1.size() == FIFO_DEPTH);
    chk("err0",   bus.err0,           m_err0);
    chk("err1",   bus.err1,           m_err1);
    chk("active", bus.active,         m_loads >= TRAIN_SYMS);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
  endtask

  initial begin
    rst_n        = 1'b0;
    bus.push0    = 1'b0;
    bus.push1    = 1'b0;
    bus.data_in0 = '0;
    bus.data_in1 = '0;

    // Reset state, then pure training and idle commas
    step(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    step(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    idle(40);

    // Single byte pushed during training waits for RUN
    step(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    idle(2);
    step(1'b1, 1'b1, 1'b0, 8'hA5, 8'h00);
    idle(50);

    // Overfill lane 0 during training
    step(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    for (int i = 1; i <= 5; i++) step(1'b1, 1'b1, 1'b0, 8'(i), 8'h00);
    idle(70);

    // Full FIFO in RUN accepts a push landing on a symbol boundary
    while (m_since != 0) idle(1);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 8'h10 + 8'(i), 8'h00);
    while (m_since != DATA_SIZE - 1) idle(1);
    step(1'b1, 1'b1, 1'b0, 8'h77, 8'h00);
    idle(45);

    // Both lanes loaded in the same slot
    step(1'b1, 1'b1, 1'b1, 8'h3C, 8'hFF);
    idle(20);

    // Random traffic with bursty phases and occasional resets
    for (int i = 0; i < 900; i++) begin
      int thr;
      bit r;
      thr = (i % 300 < 120) ? 3 : 1;
      r   = ($urandom_range(0, 249) != 0);
      step(r, $urandom_range(0, 3) < thr, $urandom_range(0, 3) < thr,
           8'($urandom), 8'($urandom));
    end

    // Reset mid-symbol with data queued discards it
    idle(40);
    while (m_since != 1) idle(1);
    step(1'b1, 1'b1, 1'b0, 8'h5A, 8'h00);
    step(1'b1, 1'b1, 1'b1, 8'h66, 8'h99);
    idle(2);
    step(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    idle(45);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
